// File: rtl/alarm_pkg.sv
// +----------------------------------------------------------------------------+
// | alarm_pkg                                                                  |
// | Shared state encoding and field widths for the alarm sequencer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alarm_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int TMR_W = 10;
  localparam int SNZ_W = 3;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZING = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sec_countdown.sv
// +----------------------------------------------------------------------------+
// | sec_countdown                                                              |
// | Loadable seconds down-counter shared by the ring and snooze phases.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sec_countdown
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             tick_i,
  output logic [TMR_W-1:0] count_o,
  output logic             done_o
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // The count parks at 1; the owner leaves the phase on the done tick.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && tick_i && (count_q > TMR_W'(1))) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = en_i && tick_i && (count_q == TMR_W'(1));

endmodule

`default_nettype wire

// File: rtl/alarm_sequencer.sv
// +----------------------------------------------------------------------------+
// | alarm_sequencer                                                            |
// | Alarm match detection and ring / snooze / stop sequencing.                 |
// | Optional feature macro: SNOOZE_LIMIT_EN (caps snoozes at MAX_SNOOZE).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Tick_1Hz,
  input  logic [HR_W-1:0]  CUR_HR,
  input  logic [MIN_W-1:0] CUR_MIN,
  input  logic [SEC_W-1:0] CUR_SEC,
  input  logic [HR_W-1:0]  AL_HR,
  input  logic [MIN_W-1:0] AL_MIN,
  input  logic             AL_switch,
  input  logic             SNOOZE_btn,
  input  logic             STOP_btn,
  output logic             AL_ON,
  output logic             SNZ_ON,
  output logic [SNZ_W-1:0] SNZ_CNT
);

`ifdef SNOOZE_LIMIT_EN
  localparam logic c_limit_en = 1'b1;
`else
  localparam logic c_limit_en = 1'b0;
`endif

  localparam logic [TMR_W-1:0] c_ring_val   = TMR_W'(RING_SECS);
  localparam logic [TMR_W-1:0] c_snooze_val = TMR_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0] c_max_snz    = SNZ_W'(MAX_SNOOZE);

  state_e           state_q, state_d;
  logic             al_on_q, al_on_d;
  logic             snz_on_q, snz_on_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_done;
  logic [TMR_W-1:0] w_tmr_count;
  logic             w_match;
  logic             w_stop;

  assign w_match = Tick_1Hz && (CUR_HR == AL_HR) && (CUR_MIN == AL_MIN) &&
                   (CUR_SEC == '0);

  // With the limit enabled, a snooze at the cap acts exactly like STOP.
  assign w_stop = STOP_btn ||
                  (c_limit_en && SNOOZE_btn && (snz_cnt_q == c_max_snz));

  always_comb begin
    state_d    = state_q;
    al_on_d    = al_on_q;
    snz_on_d   = snz_on_q;
    snz_cnt_d  = snz_cnt_q;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_en   = 1'b0;
    if (!AL_switch) begin
      state_d    = DISARMED;
      al_on_d    = 1'b0;
      snz_on_d   = 1'b0;
      snz_cnt_d  = '0;
      w_tmr_load = 1'b1;
    end else begin
      case (state_q)
        DISARMED: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (w_match) begin
            state_d    = RINGING;
            al_on_d    = 1'b1;
            snz_cnt_d  = '0;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_ring_val;
          end
        end
        RINGING: begin
          w_tmr_en = 1'b1;
          if (w_stop) begin
            state_d    = ARMED;
            al_on_d    = 1'b0;
            snz_cnt_d  = '0;
            w_tmr_load = 1'b1;
          end else if (SNOOZE_btn) begin
            state_d    = SNOOZING;
            al_on_d    = 1'b0;
            snz_on_d   = 1'b1;
            snz_cnt_d  = (snz_cnt_q == '1) ? snz_cnt_q : snz_cnt_q + SNZ_W'(1);
            w_tmr_load = 1'b1;
            w_tmr_val  = c_snooze_val;
          end else if (w_tmr_done) begin
            state_d    = ARMED;
            al_on_d    = 1'b0;
            snz_cnt_d  = '0;
            w_tmr_load = 1'b1;
          end
        end
        SNOOZING: begin
          w_tmr_en = 1'b1;
          if (STOP_btn) begin
            state_d    = ARMED;
            snz_on_d   = 1'b0;
            snz_cnt_d  = '0;
            w_tmr_load = 1'b1;
          end else if (w_tmr_done) begin
            state_d    = RINGING;
            al_on_d    = 1'b1;
            snz_on_d   = 1'b0;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_ring_val;
          end
        end
        default: begin
          state_d    = DISARMED;
          al_on_d    = 1'b0;
          snz_on_d   = 1'b0;
          snz_cnt_d  = '0;
          w_tmr_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= DISARMED;
      al_on_q   <= 1'b0;
      snz_on_q  <= 1'b0;
      snz_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      al_on_q   <= al_on_d;
      snz_on_q  <= snz_on_d;
      snz_cnt_q <= snz_cnt_d;
    end
  end

  sec_countdown u_timer (
    .clk        (Clk),
    .rst        (Reset),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .en_i       (w_tmr_en),
    .tick_i     (Tick_1Hz),
    .count_o    (w_tmr_count),
    .done_o     (w_tmr_done)
  );

  assign AL_ON   = al_on_q;
  assign SNZ_ON  = snz_on_q;
  assign SNZ_CNT = snz_cnt_q;

  logic w_unused;
  assign w_unused = ^w_tmr_count;

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_alarm_sequencer                                                         |
// | Directed self-checking bench for alarm_sequencer (RING 60 s, SNOOZE 5 s).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alarm_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick_1Hz = 1'b0;
  logic [4:0] CUR_HR = 5'd0;
  logic [5:0] CUR_MIN = 6'd0;
  logic [5:0] CUR_SEC = 6'd0;
  logic [4:0] AL_HR = 5'd7;
  logic [5:0] AL_MIN = 6'd30;
  logic       AL_switch = 1'b0;
  logic       SNOOZE_btn = 1'b0;
  logic       STOP_btn = 1'b0;
  logic       AL_ON;
  logic       SNZ_ON;
  logic [2:0] SNZ_CNT;

  int checks = 0;
  int errors = 0;

  alarm_sequencer #(
    .RING_SECS   (60),
    .SNOOZE_SECS (5),
    .MAX_SNOOZE  (3)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick_1Hz   (Tick_1Hz),
    .CUR_HR     (CUR_HR),
    .CUR_MIN    (CUR_MIN),
    .CUR_SEC    (CUR_SEC),
    .AL_HR      (AL_HR),
    .AL_MIN     (AL_MIN),
    .AL_switch  (AL_switch),
    .SNOOZE_btn (SNOOZE_btn),
    .STOP_btn   (STOP_btn),
    .AL_ON      (AL_ON),
    .SNZ_ON     (SNZ_ON),
    .SNZ_CNT    (SNZ_CNT)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input logic [5:0] sec);
    CUR_SEC  = sec;
    Tick_1Hz = 1'b1;
    step();
    Tick_1Hz = 1'b0;
    step();
  endtask

  task automatic press(input logic snz, input logic stp, input logic tk);
    SNOOZE_btn = snz;
    STOP_btn   = stp;
    Tick_1Hz   = tk;
    CUR_SEC    = 6'd7;
    step();
    SNOOZE_btn = 1'b0;
    STOP_btn   = 1'b0;
    Tick_1Hz   = 1'b0;
    step();
  endtask

  task automatic ring_start();
    CUR_HR  = 5'd7;
    CUR_MIN = 6'd30;
    tick(6'd0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    AL_switch = 1'b1;
    step();
    step();
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_ring_timeout();
    CUR_HR = 5'd7;
    CUR_MIN = 6'd29;
    tick(6'd58);
    tick(6'd59);
    checks++;
    if (AL_ON !== 1'b0) begin
      errors++;
      $display("FAIL pre_match: AL_ON=%b expected 0", AL_ON);
    end
    CUR_MIN = 6'd30;
    CUR_SEC = 6'd0;
    Tick_1Hz = 1'b1;
    step();
    Tick_1Hz = 1'b0;
    checks++;
    if (AL_ON !== 1'b1) begin
      errors++;
      $display("FAIL ring_rise: AL_ON=%b expected 1", AL_ON);
    end
    step();
    for (int i = 1; i <= 59; i++) begin
      tick(6'(i));
      checks++;
      if (AL_ON !== 1'b1) begin
        errors++;
        $display("FAIL ring_hold: tick %0d AL_ON=%b expected 1", i, AL_ON);
      end
    end
    CUR_MIN = 6'd31;
    tick(6'd0);
    checks++;
    if (AL_ON !== 1'b0) begin
      errors++;
      $display("FAIL ring_timeout: AL_ON=%b expected 0", AL_ON);
    end
    CUR_MIN = 6'd30;
    tick(6'd1);
    checks++;
    if (AL_ON !== 1'b0) begin
      errors++;
      $display("FAIL no_rering: AL_ON=%b expected 0", AL_ON);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL btn_in_armed: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
  endtask

  task automatic test_snooze();
    ring_start();
    for (int i = 1; i <= 9; i++) tick(6'(i));
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b01001) begin
      errors++;
      $display("FAIL snooze_enter: got %b expected 01001", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    for (int i = 1; i <= 4; i++) tick(6'd10);
    checks++;
    if ({AL_ON, SNZ_ON} !== 2'b01) begin
      errors++;
      $display("FAIL snooze_hold: got %b expected 01", {AL_ON, SNZ_ON});
    end
    tick(6'd10);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b10001) begin
      errors++;
      $display("FAIL snooze_rering: got %b expected 10001", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL ring_stop: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
  endtask

  task automatic test_snooze_limit();
    ring_start();
    for (int n = 1; n <= 3; n++) begin
      press(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) tick(6'd10);
      checks++;
      if ({AL_ON, SNZ_ON, SNZ_CNT} !== {2'b10, 3'(n)}) begin
        errors++;
        $display("FAIL snooze_count: n=%0d got %b expected %b", n,
                 {AL_ON, SNZ_ON, SNZ_CNT}, {2'b10, 3'(n)});
      end
    end
    press(1'b1, 1'b0, 1'b0);
`ifdef SNOOZE_LIMIT_EN
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL snooze_limit: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
`else
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b01100) begin
      errors++;
      $display("FAIL snooze_unlimited: got %b expected 01100", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    for (int n = 5; n <= 8; n++) begin
      for (int i = 1; i <= 5; i++) tick(6'd10);
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (SNZ_CNT !== ((n > 7) ? 3'd7 : 3'(n))) begin
        errors++;
        $display("FAIL snooze_saturate: n=%0d SNZ_CNT=%0d expected %0d", n, SNZ_CNT,
                 (n > 7) ? 7 : n);
      end
    end
`endif
    press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_priority();
    ring_start();
    press(1'b1, 1'b1, 1'b0);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL stop_beats_snooze: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    ring_start();
    checks++;
    if (AL_ON !== 1'b1) begin
      errors++;
      $display("FAIL rearm_after_stop: AL_ON=%b expected 1", AL_ON);
    end
    press(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) tick(6'd10);
    press(1'b0, 1'b1, 1'b1);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL stop_on_snooze_end: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    ring_start();
    for (int i = 1; i <= 59; i++) tick(6'(i));
    press(1'b1, 1'b0, 1'b1);
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b01001) begin
      errors++;
      $display("FAIL snooze_on_ring_end: got %b expected 01001", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_switch_reset();
    ring_start();
    AL_switch = 1'b0;
    step();
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL switch_off: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    ring_start();
    checks++;
    if (AL_ON !== 1'b0) begin
      errors++;
      $display("FAIL disarmed_match: AL_ON=%b expected 0", AL_ON);
    end
    AL_switch = 1'b1;
    step();
    ring_start();
    checks++;
    if (AL_ON !== 1'b1) begin
      errors++;
      $display("FAIL rearm_switch: AL_ON=%b expected 1", AL_ON);
    end
    press(1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    step();
    checks++;
    if ({AL_ON, SNZ_ON, SNZ_CNT} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_snooze: got %b expected 00000", {AL_ON, SNZ_ON, SNZ_CNT});
    end
    Reset = 1'b0;
    step();
    for (int i = 1; i <= 6; i++) tick(6'd10);
    checks++;
    if ({AL_ON, SNZ_ON} !== 2'b00) begin
      errors++;
      $display("FAIL no_resume: got %b expected 00", {AL_ON, SNZ_ON});
    end
    ring_start();
    checks++;
    if ({AL_ON, SNZ_CNT} !== 4'b1000) begin
      errors++;
      $display("FAIL armed_after_reset: got %b expected 1000", {AL_ON, SNZ_CNT});
    end
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_snooze_limit();
    test_priority();
    test_switch_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
